// File: rtl/fifo_pkg.sv
// Shared types for the fifo read-side drain controller.
// Holds the FSM state enum, buffer depth and timer width.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } drain_state_t;

  localparam int BUF_DEPTH = 3;
  localparam int TIMER_W   = 8;

  function automatic logic [1:0] ptr_inc(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/drain_buf.sv
// Three-entry circular output buffer for fifo_drain.
// Captures arriving FIFO words and presents the head entry.
module drain_buf
  import fifo_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   occ_o
);

  logic [W-1:0] mem_q [BUF_DEPTH];
  logic [W-1:0] mem_d [BUF_DEPTH];
  logic [1:0]   wr_q, wr_d;
  logic [1:0]   rd_q, rd_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;

  assign valid_o = (occ_q != 2'd0);
  assign pop     = valid_o && ready_i;
  assign data_o  = mem_q[rd_q];
  assign occ_o   = occ_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    if (clr_i) begin
      wr_d  = 2'd0;
      rd_d  = 2'd0;
      occ_d = 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = push_data_i;
        wr_d        = ptr_inc(wr_q);
      end
      if (pop) begin
        rd_d = ptr_inc(rd_q);
      end
      unique case ({push_i, pop})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      occ_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// Read-side burst drain controller for the dual-port fifo.
// Define FIFO_DRAIN_CNT_EN to add the WORD_CNT pop counter.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int mem_depth    = 32,
  parameter int mem_width    = 8,
  parameter int burst_min    = 4,
  parameter int idle_timeout = 16
) (
  input  logic                       CLOCK,
  input  logic                       RESET_N,
  input  logic                       CLEAR_N,
  input  logic                       F_EMPTY_N,
  input  logic [$clog2(mem_depth):0] USE_DW,
  input  logic [mem_width-1:0]       FIFO_DATA,
  output logic                       READ,
  output logic [mem_width-1:0]       DOUT,
  output logic                       DOUT_VALID,
  input  logic                       DOUT_READY
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0]                WORD_CNT
`endif
);

  localparam int AW = $clog2(mem_depth) + 1;
  localparam logic [AW-1:0] BMIN = AW'(burst_min);
  localparam logic [TIMER_W-1:0] TOUT_M1 = TIMER_W'(idle_timeout - 1);

  drain_state_t       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               inflight_q;
  logic [1:0]         occ;
  logic               credit;
  logic               full_lvl;

  assign full_lvl = (USE_DW >= BMIN);
  // Words in the buffer plus the one in flight must fit in three slots.
  assign credit = ({1'b0, occ} + {2'b00, inflight_q}) < 3'd3;

  assign READ = CLEAR_N && (state_q == DRAIN) && F_EMPTY_N
             && (USE_DW != '0) && credit;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (!CLEAR_N) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (full_lvl) begin
            state_d = DRAIN;
          end else if (F_EMPTY_N) begin
            state_d = WAIT;
            timer_d = '0;
          end
        end
        WAIT: begin
          if (full_lvl || timer_q >= TOUT_M1) begin
            state_d = DRAIN;
          end else if (!F_EMPTY_N) begin
            state_d = IDLE;
          end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
          end
        end
        DRAIN: begin
          if (USE_DW == '0 && !inflight_q) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      inflight_q <= READ;
    end
  end

  drain_buf #(
    .W (mem_width)
  ) u_buf (
    .clk_i       (CLOCK),
    .rst_ni      (RESET_N),
    .clr_i       (!CLEAR_N),
    .push_i      (inflight_q && CLEAR_N),
    .push_data_i (FIFO_DATA),
    .ready_i     (DOUT_READY),
    .valid_o     (DOUT_VALID),
    .data_o      (DOUT),
    .occ_o       (occ)
  );

`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!CLEAR_N) begin
      cnt_d = '0;
    end else if (DOUT_VALID && DOUT_READY) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign WORD_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboard bench for fifo_drain with a behavioural FIFO model.
// Stimulus queues expected words; a negedge monitor checks pops.
module tb_fifo_drain;

  logic       CLOCK = 1'b0;
  logic       RESET_N;
  logic       CLEAR_N;
  logic       F_EMPTY_N = 1'b0;
  logic [5:0] USE_DW = '0;
  logic [7:0] FIFO_DATA = '0;
  logic       READ;
  logic [7:0] DOUT;
  logic       DOUT_VALID;
  logic       DOUT_READY;
`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] WORD_CNT;
`endif

  fifo_drain dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .CLEAR_N    (CLEAR_N),
    .F_EMPTY_N  (F_EMPTY_N),
    .USE_DW     (USE_DW),
    .FIFO_DATA  (FIFO_DATA),
    .READ       (READ),
    .DOUT       (DOUT),
    .DOUT_VALID (DOUT_VALID),
    .DOUT_READY (DOUT_READY)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .WORD_CNT   (WORD_CNT)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;

  logic [7:0] fq [$];
  logic [7:0] exp_q [$];
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       fflush = 1'b0;

  // Behavioural FIFO: one-cycle read latency, writes land at the edge.
  always @(posedge CLOCK) begin
    if (fflush) begin
      fq.delete();
    end else begin
      if (READ && fq.size() != 0) FIFO_DATA <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
    end
    USE_DW    <= 6'(fq.size());
    F_EMPTY_N <= (fq.size() != 0);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge CLOCK) begin
    if (READ) rd_cnt++;
    if (RESET_N && DOUT_VALID && DOUT_READY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_pop act=%0h exp=none", DOUT);
      end else begin
        chk("dout", {24'd0, DOUT}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit track);
    wr_en   = 1'b1;
    wr_data = d;
    if (track) exp_q.push_back(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input bit toggle);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || DOUT_VALID); i++) begin
      if (toggle) DOUT_READY = ~DOUT_READY;
      tick();
    end
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, last_rd, nrd, first_v, base;
    RESET_N    = 1'b0;
    CLEAR_N    = 1'b1;
    DOUT_READY = 1'b0;
    #2;
    chk("rst_valid", DOUT_VALID, 0);
    chk("rst_read", READ, 0);
    chk("rst_dout", DOUT, 0);
    tick();
    tick();
    RESET_N = 1'b1;
    tick();

    // Threshold burst
    DOUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'(8'h11 + i), 1'b1);
    first_rd = -1;
    last_rd  = -1;
    first_v  = -1;
    nrd      = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (READ) begin
        if (first_rd < 0) first_rd = c;
        last_rd = c;
        nrd++;
      end
      if (DOUT_VALID && first_v < 0) first_v = c;
    end
    chk("burst_reads", nrd, 4);
    chk("burst_consec", last_rd - first_rd, 3);
    chk("burst_lat", first_v - first_rd, 2);
    wait_drain(1'b0);
    tick();
    tick();

    // Idle timeout
    wr(8'h5A, 1'b1);
    first_rd = -1;
    nrd      = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (READ) begin
        if (first_rd < 0) first_rd = c;
        nrd++;
      end
    end
    chk("tout_first", first_rd, 17);
    chk("tout_reads", nrd, 1);
    wait_drain(1'b0);

    // Backpressure
    DOUT_READY = 1'b0;
    base = rd_cnt;
    for (int i = 0; i < 8; i++) wr(8'(8'h20 + i), 1'b1);
    for (int c = 0; c < 12; c++) tick();
    chk("bp_reads", rd_cnt - base, 3);
    chk("bp_valid", DOUT_VALID, 1);
    chk("bp_head", DOUT, 8'h20);
    DOUT_READY = 1'b1;
    wait_drain(1'b0);

    // Clear with a read in flight
    wr(8'h30, 1'b0);
    for (int i = 1; i < 4; i++) wr(8'(8'h30 + i), 1'b1);
    for (int n = 0; n < 40 && !READ; n++) tick();
    chk("clr_rd_seen", READ, 1);
    tick();
    CLEAR_N = 1'b0;
    #1;
    chk("clr_read0", READ, 0);
    tick();
    CLEAR_N = 1'b1;
    chk("clr_valid", DOUT_VALID, 0);
    wait_drain(1'b0);

    // Reset while occ=2
    DOUT_READY = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'(8'h40 + i), 1'b0);
    for (int n = 0; n < 40 && !READ; n++) tick();
    chk("rm_rd_seen", READ, 1);
    tick();
    tick();
    tick();
    chk("rm_valid_pre", DOUT_VALID, 1);
    RESET_N = 1'b0;
    #1;
    chk("rm_valid", DOUT_VALID, 0);
    chk("rm_read", READ, 0);
    chk("rm_dout", DOUT, 0);
    fflush = 1'b1;
    tick();
    fflush = 1'b0;
    RESET_N = 1'b1;
    tick();
    chk("rm_idle_valid", DOUT_VALID, 0);
    DOUT_READY = 1'b1;
    base = rd_cnt;
    wr(8'h60, 1'b1);
    tick();
    tick();
    tick();
    chk("rm_idle_noread", rd_cnt - base, 0);
    wait_drain(1'b0);

    // Clear the counter, then wrap with a toggling sink
    CLEAR_N = 1'b0;
    tick();
    CLEAR_N = 1'b1;
    DOUT_READY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      DOUT_READY = ~DOUT_READY;
      wr(8'(8'h50 + i), 1'b1);
    end
    wait_drain(1'b1);
`ifdef FIFO_DRAIN_CNT_EN
    chk("word_cnt", WORD_CNT, 10);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side controller for the dual-port `fifo`: issues `READ` pulses to the FIFO and absorbs its one-cycle read latency. It forwards words to a downstream consumer over a valid/ready stream. It accumulates words into bursts using a fill threshold or an idle timeout, and applies backpressure by withholding reads. It sits between `fifo` and any stream sink in the datapath.

## Interface
- `mem_depth`, 32: depth of the attached FIFO.
- `mem_width`, 8: data word width.
- `burst_min`, 4: `USE_DW` level that starts a drain burst; range 1..`mem_depth`.
- `idle_timeout`, 16: cycles a non-empty FIFO may sit below `burst_min` before draining anyway; range 1..255.

Ports:
- `CLOCK`  in  1  single clock, rising edge.
- `RESET_N`  in  1  asynchronous active-low reset.
- `CLEAR_N`  in  1  synchronous active-low flush.
- `F_EMPTY_N`  in  1  FIFO not-empty flag.
- `USE_DW`  in  $clog2(mem_depth)+1  FIFO occupancy.
- `FIFO_DATA`  in  mem_width  FIFO `DATA_OUT`, valid one cycle after `READ`.
- `READ`  out  1  FIFO read strobe, one word per high cycle.
- `DOUT`  out  mem_width  output word.
- `DOUT_VALID`  out  1  `DOUT` holds a word.
- `DOUT_READY`  in  1  sink accepts the word this cycle.

## Operation
- States:
  - `IDLE`: FIFO empty, or no burst pending.
  - `WAIT`: FIFO non-empty but below threshold; timer running.
  - `DRAIN`: reading.
- Transitions:
  - `IDLE`→`DRAIN` when `USE_DW >= burst_min`.
  - `IDLE`→`WAIT` when `F_EMPTY_N=1` and `USE_DW < burst_min`.
  - `WAIT`→`DRAIN` when `USE_DW >= burst_min`, or when the timer reaches `idle_timeout`.
  - `WAIT`→`IDLE` if the FIFO becomes empty.
  - `DRAIN`→`IDLE` when `USE_DW == 0` and no read is in flight.
- Timer: 8-bit. Cleared on entry to `WAIT`; increments each `WAIT` cycle; saturates.
- Read issue: `READ = (state==DRAIN) && F_EMPTY_N && USE_DW != 0 && (occ + inflight) < 3`.
  - `READ` is combinational from registered state plus the FIFO inputs.
  - `READ` never depends on `DOUT_READY`.
- `inflight` is a 1-bit register equal to `READ` delayed by one cycle. When it is 1, `FIFO_DATA` is captured into the output buffer.
- Output buffer: 3-entry circular buffer.
  - `occ` is 0..3; 2-bit pointers wrap 2→0.
  - `DOUT` is the head entry; `DOUT_VALID = (occ != 0)`.
  - A pop occurs on `DOUT_VALID && DOUT_READY`.
- Simultaneous capture and pop in the same cycle leave `occ` unchanged.
- The credit rule guarantees `occ <= 3`; overflow is unreachable.
- `CLEAR_N=0` at a clock edge:
  - `occ`, pointers, `inflight` and timer go to 0; state goes to `IDLE`.
  - A word arriving from a read issued in the previous cycle is discarded.
  - `READ` is forced 0 during that cycle.
- `RESET_N` low (asynchronous, any state): same effect as clear, applied immediately.
  - Reset values: `READ=0` (combinational, since state is `IDLE`), `DOUT=0`, `DOUT_VALID=0`.

## Timing
- Latency from `READ` high in cycle t: capture at the edge ending t+1, `DOUT_VALID=1` from t+2.
- Throughput is one word per cycle while `DOUT_READY=1` and the FIFO is non-empty.
- `DOUT`/`DOUT_VALID` are stable until popped. The sink may hold `DOUT_READY` low indefinitely.
- With `DOUT_READY=0`, at most 3 reads are issued, then `READ` stays 0.
- The minimum `WAIT` dwell before a timeout drain is `idle_timeout` cycles. The first `READ` comes one cycle after the timeout.

## Configuration
- `FIFO_DRAIN_CNT_EN` defined:
  - Adds output port `WORD_CNT` (16-bit) counting accepted pops; it wraps at 65535→0.
  - It is cleared by `RESET_N` or `CLEAR_N`.
- `FIFO_DRAIN_CNT_EN` undefined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `fifo_pkg`:
  - state enum `drain_state_t` (`IDLE`, `WAIT`, `DRAIN`);
  - `BUF_DEPTH = 3`;
  - `TIMER_W = 8`.
- One sub-module: `drain_buf`, the 3-entry output buffer (capture, pop, `occ`, head data). The FSM and read logic stay in `fifo_drain`.

## Test plan
- Reset mid-drain: `RESET_N` low while `occ=2` → `DOUT_VALID=0` and `READ=0` immediately. After release, state is `IDLE`.
- Threshold burst: write 4 words (0x11..0x14) with `DOUT_READY=1` → `READ` high 4 consecutive cycles. `DOUT` shows 0x11..0x14 on consecutive cycles, starting 2 cycles after the first `READ`.
- Timeout: 1 word, `USE_DW=1` held → `READ` asserted after exactly 16 `WAIT` cycles, then `IDLE`.
- Backpressure: 8 words, `DOUT_READY=0` → exactly 3 `READ`s and `DOUT` holds word 0. Raising `DOUT_READY` then drains the remaining words in order with no loss.
- Clear with read in flight: `CLEAR_N=0` in the cycle after a `READ` → the arriving word is dropped and `occ=0`.
- Wrap and count (`FIFO_DRAIN_CNT_EN`): 10 words with `DOUT_READY` toggling every cycle → buffer pointers wrap, output order is preserved, `WORD_CNT=10`.
